// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - DEPTH x WIDTH register file, 1W/2R, per-register pending scoreboard
// Optional write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             WriteEnable,
   input  logic [AW-1:0]    WriteReg,
   input  logic [WIDTH-1:0] WriteData,
   input  logic             ReadEnable1,
   input  logic [AW-1:0]    ReadReg1,
   output logic [WIDTH-1:0] ReadData1,
   output logic             ReadValid1,
   input  logic             ReadEnable2,
   input  logic [AW-1:0]    ReadReg2,
   output logic [WIDTH-1:0] ReadData2,
   output logic             ReadValid2,
   input  logic             ReserveEnable,
   input  logic [AW-1:0]    ReserveReg,
   output logic             ReserveAck,
   output logic [AW:0]      PendingCount
);

   logic [WIDTH-1:0] reg_q [DEPTH];
   logic [WIDTH-1:0] reg_d [DEPTH];
   logic [DEPTH-1:0] pending_q, pending_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_hit;

   assign wr_hit = WriteEnable && (WriteReg != '0);

   // A write landing on the same register this cycle frees the slot for the new producer.
   assign ReserveAck = ReserveEnable && !rst &&
                       ((ReserveReg == '0) || !pending_q[ReserveReg] ||
                        (WriteEnable && (WriteReg == ReserveReg)));

   always_comb begin
      reg_d     = reg_q;
      pending_d = pending_q;
      if (wr_hit) begin
         reg_d[WriteReg]     = WriteData;
         pending_d[WriteReg] = 1'b0;
      end
      if (ReserveAck && (ReserveReg != '0)) begin
         pending_d[ReserveReg] = 1'b1;
      end
      pending_d[0] = 1'b0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_d = count_d + (AW+1)'(pending_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            reg_q[i] <= '0;
         end
         pending_q <= '0;
         count_q   <= '0;
      end else begin
         reg_q     <= reg_d;
         pending_q <= pending_d;
         count_q   <= count_d;
      end
   end

   assign PendingCount = count_q;

   always_comb begin
      ReadData1  = '0;
      ReadValid1 = 1'b0;
      if (ReadEnable1) begin
         if (ReadReg1 == '0) begin
            ReadValid1 = 1'b1;
         end
`ifdef REGFILE_BYPASS_EN
         else if (wr_hit && (WriteReg == ReadReg1)) begin
            ReadData1  = WriteData;
            ReadValid1 = 1'b1;
         end
`endif
         else begin
            ReadData1  = reg_q[ReadReg1];
            ReadValid1 = !pending_q[ReadReg1];
         end
      end
   end

   always_comb begin
      ReadData2  = '0;
      ReadValid2 = 1'b0;
      if (ReadEnable2) begin
         if (ReadReg2 == '0) begin
            ReadValid2 = 1'b1;
         end
`ifdef REGFILE_BYPASS_EN
         else if (wr_hit && (WriteReg == ReadReg2)) begin
            ReadData2  = WriteData;
            ReadValid2 = 1'b1;
         end
`endif
         else begin
            ReadData2  = reg_q[ReadReg2];
            ReadValid2 = !pending_q[ReadReg2];
         end
      end
   end

endmodule
